// File: rtl/rev_pkg.sv
// Shared types and default sizing for the rev-counter path (divider, gate counter, display).
package rev_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam int GATE_CYCLES_DEF = 5_000_000;
    localparam int CNT_W_DEF       = 16;
    localparam int DEB_CYCLES_DEF  = 1000;

endpackage

// File: rtl/rev_pulse_sync.sv
// Sensor front end: 2-FF synchronizer, optional debounce (REV_GATE_DEBOUNCE_EN), rising-edge detect.
// edge_o is a one-cycle pulse driven only from registers.
module rev_pulse_sync
    import rev_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= pulse_i;
            sync_q <= meta_q;
        end
    end

`ifdef REV_GATE_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt_q;
    logic             filt_q;

    // The filtered level flips only after sync_q disagrees with it for DEB_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_q <= '0;
            filt_q    <= 1'b0;
        end else if (sync_q == filt_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q <= '0;
            filt_q    <= sync_q;
        end else begin
            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
    end

    assign level = filt_q;
`else
    // Filter length has no effect when the debounce build is off.
    logic unused_deb_cfg;
    assign unused_deb_cfg = (DEB_CYCLES > 0);

    assign level = sync_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign edge_o = level & ~prev_q;

endmodule

// File: rtl/rev_gate_counter.sv
// Revolution counter: counts sensor edges over back-to-back windows of GATE_CYCLES clocks.
// Define REV_GATE_DEBOUNCE_EN to insert the debounce filter ahead of the edge detector.
module rev_gate_counter
    import rev_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [CNT_W-1:0]  pulse_cnt_q;
    logic [CNT_W-1:0]  pulse_cnt_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              valid_q;
    logic              busy_q;
    logic              edge_pulse;
    logic              terminal;

    rev_pulse_sync #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .pulse_i(pulse_in),
        .edge_o (edge_pulse)
    );

    // Pulse count including this cycle's edge; saturates and raises the sticky flag instead of wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pulse_cnt_d = pulse_cnt_q;
        ovf_d       = ovf_q;
        if (edge_pulse) begin
            if (pulse_cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
            end
        end
    end

    assign terminal = (state_q == GATE) && (gate_cnt_q == GATE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    gate_cnt_q  <= '0;
                    pulse_cnt_q <= '0;
                    ovf_q       <= 1'b0;
                    if (en) begin
                        state_q <= GATE;
                        busy_q  <= 1'b1;
                    end
                end
                GATE: begin
                    if (terminal) begin
                        // Publish even if en dropped this cycle; the next window starts with no gap.
                        count_q     <= pulse_cnt_d;
                        overflow_q  <= ovf_d;
                        valid_q     <= 1'b1;
                        gate_cnt_q  <= '0;
                        pulse_cnt_q <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= en ? GATE : IDLE;
                        busy_q      <= en;
                    end else if (!en) begin
                        gate_cnt_q  <= '0;
                        pulse_cnt_q <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end else begin
                        gate_cnt_q  <= gate_cnt_q + GATE_W'(1);
                        pulse_cnt_q <= pulse_cnt_d;
                        ovf_q       <= ovf_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rev_gate_counter.sv
// Bench for rev_gate_counter: directed windows with literal expectations plus a random phase,
// all outputs compared every cycle against a window-level behavioural model.
module tb_rev_gate_counter;

    localparam int GATE_CYCLES = 100;
    localparam int CNT_W       = 4;
    localparam int DEB         = 4;
    localparam int MAXC        = (1 << CNT_W) - 1;

`ifdef REV_GATE_DEBOUNCE_EN
    localparam int PH = 6;
    localparam int PL = 6;
    localparam int RUN_MAX = 9;
`else
    localparam int PH = 3;
    localparam int PL = 3;
    localparam int RUN_MAX = 6;
`endif

    logic             clk;
    logic             rst;
    logic             en;
    logic             pulse_in;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             overflow;
    logic             busy;

    int tests = 0;
    int fails = 0;

    rev_gate_counter #(
        .GATE_CYCLES(GATE_CYCLES),
        .CNT_W      (CNT_W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pulse_in   (pulse_in),
        .count      (count),
        .count_valid(count_valid),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Levels reaching the edge detector are derived from the history of sampled pulse_in values;
    // each window accumulates an unbounded integer and publishes min(raw, MAXC) with raw > MAXC as overflow.
    bit               p_hist [0:7];
    bit               lvl_cur, lvl_prev;
    bit               in_win;
    int               win_pos, raw;
    logic [CNT_W-1:0] exp_count = '0;
    bit               exp_valid, exp_ovf, exp_busy;
    bit               chk_en = 1'b0;

    always @(posedge clk) begin
        bit hit, nxt, same;
        if (rst) begin
            for (int i = 0; i < 8; i++) p_hist[i] = 1'b0;
            lvl_cur   = 1'b0;
            lvl_prev  = 1'b0;
            in_win    = 1'b0;
            win_pos   = 0;
            raw       = 0;
            exp_count = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_busy  = 1'b0;
            chk_en    = 1'b1;
        end else begin
            hit = lvl_cur & ~lvl_prev;
            exp_valid = 1'b0;
            if (!in_win) begin
                if (en) begin
                    in_win  = 1'b1;
                    win_pos = 0;
                    raw     = 0;
                end
            end else begin
                raw += int'(hit);
                if (win_pos == GATE_CYCLES - 1) begin
                    exp_count = (raw > MAXC) ? CNT_W'(MAXC) : CNT_W'(raw);
                    exp_ovf   = (raw > MAXC);
                    exp_valid = 1'b1;
                    win_pos   = 0;
                    raw       = 0;
                    in_win    = en;
                end else if (!en) begin
                    in_win  = 1'b0;
                    win_pos = 0;
                    raw     = 0;
                end else begin
                    win_pos++;
                end
            end
            exp_busy = in_win;
`ifdef REV_GATE_DEBOUNCE_EN
            same = 1'b1;
            for (int i = 2; i <= DEB; i++) if (p_hist[i] != p_hist[1]) same = 1'b0;
            nxt = same ? p_hist[1] : lvl_cur;
`else
            same = 1'b0;
            nxt  = p_hist[0];
`endif
            lvl_prev = lvl_cur;
            lvl_cur  = nxt;
            for (int i = 7; i > 0; i--) p_hist[i] = p_hist[i-1];
            p_hist[0] = pulse_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count", count, exp_count);
            check("model_valid", count_valid, exp_valid);
            check("model_overflow", overflow, exp_ovf);
            check("model_busy", busy, exp_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_pulses(input int n, input int ph, input int pl);
        for (int i = 0; i < n; i++) begin
            pulse_in = 1'b1;
            repeat (ph) @(negedge clk);
            pulse_in = 1'b0;
            repeat (pl) @(negedge clk);
        end
    endtask

    task automatic wait_strobe(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (count_valid) return;
        end
        check("strobe_timeout", 32'd0, 32'd1);
    endtask

    int cyc;
    int strobes;
    int last_lit;
    int run_left;

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        pulse_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_count", count, 0);
        check("reset_valid", count_valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);

        // Idle input: a zero result every 100 cycles, busy held high.
        rst = 1'b0;
        en  = 1'b1;
        wait_strobe(150, cyc);
        check("first_strobe_latency", cyc, 101);
        check("idle_count", count, 0);
        wait_strobe(150, cyc);
        check("window_period", cyc, 100);
        check("idle_count2", count, 0);
        check("idle_overflow", overflow, 0);
        check("busy_high", busy, 1);

        send_pulses(7, PH, PL);
        wait_strobe(150, cyc);
        check("seven_pulses", count, 7);
        check("seven_overflow", overflow, 0);
        wait_strobe(150, cyc);
        check("empty_after_seven", count, 0);

`ifdef REV_GATE_DEBOUNCE_EN
        send_pulses(5, 2, 3);
        wait_strobe(150, cyc);
        check("glitches_ignored", count, 0);
        send_pulses(6, 10, 5);
        wait_strobe(150, cyc);
        check("long_pulses", count, 6);
        last_lit = 6;
`else
        send_pulses(20, 2, 2);
        wait_strobe(150, cyc);
        check("saturated_count", count, 15);
        check("saturated_overflow", overflow, 1);
        send_pulses(2, PH, PL);
        wait_strobe(150, cyc);
        check("after_sat_count", count, 2);
        check("after_sat_overflow", overflow, 0);
        last_lit = 2;
`endif

        // Abort at gate cycle 50 after 5 pulses.
`ifdef REV_GATE_DEBOUNCE_EN
        send_pulses(5, 5, 5);
`else
        send_pulses(5, 3, 3);
        repeat (20) @(negedge clk);
`endif
        en = 1'b0;
        strobes = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (count_valid) strobes++;
        end
        check("abort_no_strobe", strobes, 0);
        check("abort_count_held", count, last_lit);
        check("abort_overflow_held", overflow, 0);
        check("abort_idle", busy, 0);

        en = 1'b1;
        wait_strobe(200, cyc);
        check("fresh_window_len", cyc, 101);
        check("fresh_window_count", count, 0);
        send_pulses(4, PH, PL);
        wait_strobe(150, cyc);
        check("four_pulses", count, 4);

        // Reset mid-window with pulses already counted.
        send_pulses(3, PH, PL);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", count_valid, 0);
        rst = 1'b0;

        // Random phase: random pulse run lengths, occasional en toggles and resets.
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                pulse_in = ~pulse_in;
                run_left = $urandom_range(1, RUN_MAX);
            end
            run_left--;
            if ($urandom_range(0, 199) == 0) en = ~en;
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
